// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and constants for the 4x4 keypad scanner.
//   state_t    : scanner FSM states (SCAN, DEBOUNCE, HELD)
//   KEY_W      : width of the {row_idx, col_idx} key code
//   ROWS/COLS  : keypad geometry
//   ROW_RESET  : row strobe driven out of reset (row 0)
// Helpers: one-hot test, one-hot to index, index to column mask, row rotate.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    localparam logic [ROWS-1:0] ROW_RESET = 4'b0001;

    // Exactly one bit set; zero and multi-key patterns both return 0.
    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // Index of the set bit of a one-hot nibble.
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] col_mask(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // 0001 -> 0010 -> 0100 -> 1000 -> 0001
    function automatic logic [3:0] next_row(input logic [3:0] r);
        return {r[2:0], r[3]};
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// keypad_scan_tick
// Row-slot divider: counts 0..SCAN_DIV-1 and asserts tick while the count
// sits at SCAN_DIV-1, i.e. for the last clock of every row slot.
// Ports:
//   clock_100Mhz : system clock
//   reset        : synchronous active-high, clears the count
//   tick         : one-cycle end-of-slot strobe
module keypad_scan_tick #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clock_100Mhz,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Row-scanning front end for a 4x4 keypad. Drives one-hot row strobes,
// samples the column returns once per row slot, debounces one key and emits
// one key_valid strobe per accepted press.
// Configuration macro: KEYPAD_DEBOUNCE_EN
//   defined   : press and release each need DEBOUNCE_SCANS matching ticks
//   undefined : a one-hot detect is accepted at once, a single zero tick
//               releases, DEBOUNCE_SCANS has no effect on behaviour
// Ports:
//   clock_100Mhz : system clock
//   reset        : synchronous active-high
//   in[3:0]      : column returns, active-high, asynchronous
//   out[3:0]     : row strobes, one-hot
//   key_code[3:0]: {row_idx, col_idx} of the last accepted key
//   key_valid    : one-cycle strobe, key_code valid in the same cycle
//   key_held     : high from acceptance until the release is confirmed
//   fsm_state    : current FSM state, for observation
//
// Handshake: key_valid is a pure strobe with no ready/backpressure. The
// consumer must capture key_code in the cycle key_valid is high; key_code
// stays stable afterwards until the next acceptance.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clock_100Mhz,
    input  logic             reset,
    input  logic [COLS-1:0]  in,
    output logic [ROWS-1:0]  out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held,
    output state_t           fsm_state
);

    // Counters are sized for the largest configured scan count.
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int RELEASE_SCANS = DEBOUNCE_SCANS;
`else
    localparam int RELEASE_SCANS = 1;
`endif

    // Compared against the count *before* the current tick, so reaching the
    // threshold and acting on it happen on the same tick.
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_SCANS - 1);

    logic [COLS-1:0]  col_m;
    logic [COLS-1:0]  col_s;
    logic             tick;
    logic [KEY_W-1:0] det_code;
    logic [CNT_W-1:0] rel_cnt;
    state_t           state;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] ACCEPT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
    logic [CNT_W-1:0] match_cnt;
    logic [KEY_W-1:0] lat_code;
`endif

    keypad_scan_tick #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clock_100Mhz(clock_100Mhz),
        .reset       (reset),
        .tick        (tick)
    );

    // out is always one-hot, so its index is the row currently being scanned.
    assign det_code  = {onehot_idx(out), onehot_idx(col_s)};
    assign fsm_state = state;

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            col_m     <= '0;
            col_s     <= '0;
            state     <= SCAN;
            out       <= ROW_RESET;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            rel_cnt   <= '0;
`ifdef KEYPAD_DEBOUNCE_EN
            match_cnt <= '0;
            lat_code  <= '0;
`endif
        end else begin
            col_m     <= in;
            col_s     <= col_m;
            key_valid <= 1'b0;

            if (tick) begin
                case (state)
                    SCAN: begin
                        if (is_onehot(col_s)) begin
`ifdef KEYPAD_DEBOUNCE_EN
                            if (DEBOUNCE_SCANS <= 1) begin
                                // The detect tick alone satisfies the count.
                                key_code  <= det_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                rel_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                lat_code  <= det_code;
                                match_cnt <= CNT_W'(1);
                                state     <= DEBOUNCE;
                            end
`else
                            key_code  <= det_code;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            rel_cnt   <= '0;
                            state     <= HELD;
`endif
                        end else begin
                            out <= next_row(out);
                        end
                    end

`ifdef KEYPAD_DEBOUNCE_EN
                    DEBOUNCE: begin
                        // Multi-key patterns never equal the single latched mask.
                        if (col_s == col_mask(lat_code[1:0])) begin
                            if (match_cnt == ACCEPT_LAST) begin
                                key_code  <= lat_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                rel_cnt   <= '0;
                                state     <= HELD;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            out   <= next_row(out);
                            state <= SCAN;
                        end
                    end
`endif

                    HELD: begin
                        if (col_s == '0) begin
                            if (rel_cnt == REL_LAST) begin
                                out      <= next_row(out);
                                key_held <= 1'b0;
                                rel_cnt  <= '0;
                                state    <= SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + 1'b1;
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end

                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SD = 8;
    localparam int DB = 3;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int D_EFF = DB;
`else
    localparam int D_EFF = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    int base = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [3:0] col_in;
    logic [3:0] out_w;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    keypad_pkg::state_t fsm_state;

    // Stimulus source: raw column pattern, or a keypad model where the
    // pressed key returns on its column only while its row is strobed.
    logic       raw_mode = 1'b1;
    logic [3:0] raw_in = 4'b0000;
    logic       key_down = 1'b0;
    logic [1:0] key_r = 2'd0;
    logic [1:0] key_c = 2'd0;
    logic [3:0] one4 = 4'b0001;

    assign col_in = raw_mode ? raw_in :
                    ((key_down && out_w[key_r]) ? (one4 << key_c) : 4'b0000);

    keypad_scanner #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clock_100Mhz(clk),
        .reset       (reset),
        .in          (col_in),
        .out         (out_w),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .fsm_state   (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    int lo_q[$];
    int hi_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc - base);
        end
    endfunction

    function automatic void expect_key(input logic [3:0] code, input int lo, input int hi);
        exp_q.push_back(code);
        lo_q.push_back(lo);
        hi_q.push_back(hi);
    endfunction

    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        logic [3:0] e;
        int lo;
        int hi;
        if (!reset) begin
            check("out_onehot", 32'($countones(out_w)), 32'd1);
            if (key_valid) begin
                check("valid_with_held", 32'(key_held), 32'd1);
                check("valid_single_cycle", 32'(prev_valid), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid act=%b exp=none (cycle %0d)", key_code, cyc - base);
                end else begin
                    e  = exp_q.pop_front();
                    lo = lo_q.pop_front();
                    hi = hi_q.pop_front();
                    check("key_code", 32'(key_code), 32'(e));
                    checks++;
                    if (cyc < lo || cyc > hi) begin
                        errors++;
                        $display("FAIL valid_cycle act=%0d exp=[%0d..%0d]", cyc - base, lo - base, hi - base);
                    end
                end
            end
            prev_valid = key_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        base = cyc;
    endtask

    task automatic wait_to(input int k);
        while (cyc - base < k) @(negedge clk);
    endtask

    // First slot-end tick at or after cycle t (divider runs from reset).
    function automatic int tick_at_or_after(input int t);
        int ft;
        ft = t;
        while (ft % SD != SD - 1) ft++;
        return ft;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_out"}, 32'(out_w), 32'h1);
        check({tag, "_valid"}, 32'(key_valid), 32'd0);
        check({tag, "_held"}, 32'(key_held), 32'd0);
        check({tag, "_code"}, 32'(key_code), 32'd0);
        check({tag, "_state"}, 32'(fsm_state), 32'(keypad_pkg::SCAN));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int fall;
        int p;
        int hi;
        logic [3:0] pat;

        // Idle rotation from reset
        raw_mode = 1'b1;
        raw_in = 4'b0000;
        do_reset();
        check_reset_values("rst");
        wait_to(7);  check("rot_c7", 32'(out_w), 32'h1);
        wait_to(8);  check("rot_c8", 32'(out_w), 32'h2);
        wait_to(31); check("rot_c31", 32'(out_w), 32'h8);
        wait_to(32); check("rot_c32", 32'(out_w), 32'h1);

        // Key on column 1 held from reset: row 0 detect at tick 7
        raw_in = 4'b0010;
        do_reset();
        expect_key(4'b0001, base + SD * D_EFF, base + SD * D_EFF);
        wait_to(SD * D_EFF + 1);
        check("press_held", 32'(key_held), 32'd1);
        check("press_out_frozen", 32'(out_w), 32'h1);
        wait_to(40);
        check("press_held_c40", 32'(key_held), 32'd1);
        check("press_out_c40", 32'(out_w), 32'h1);
        // Release at cycle 40: zero visible after the synchronizer
        raw_in = 4'b0000;
        fall = tick_at_or_after(42) + (D_EFF - 1) * SD + 1;
        wait_to(fall - 1);
        check("release_still_held", 32'(key_held), 32'd1);
        wait_to(fall);
        check("release_held_low", 32'(key_held), 32'd0);
        check("release_out_next", 32'(out_w), 32'h2);
        wait_to(fall + 40);
        check("press_accepted_once", 32'(exp_q.size()), 32'd0);

        // Bounce: column 2 for the row-2 slot only
        raw_in = 4'b0000;
        do_reset();
        wait_to(16);
        check("bounce_row2", 32'(out_w), 32'h4);
        raw_in = 4'b0100;
        wait_to(24);
        raw_in = 4'b0000;
`ifndef KEYPAD_DEBOUNCE_EN
        expect_key(4'b1010, base + 24, base + 24);
`endif
        wait_to(28); check("bounce_frozen", 32'(out_w), 32'h4);
        wait_to(32); check("bounce_resume", 32'(out_w), 32'h8);
        check("bounce_not_held", 32'(key_held), 32'd0);
        wait_to(40);
        check("bounce_queue", 32'(exp_q.size()), 32'd0);

        // Two columns at once: never detected
        raw_in = 4'b0011;
        do_reset();
        wait_to(32);
        check("multi_rotates", 32'(out_w), 32'h1);
        check("multi_not_held", 32'(key_held), 32'd0);
        wait_to(40);

        // Reset pulse while debouncing
        raw_in = 4'b0010;
        do_reset();
`ifndef KEYPAD_DEBOUNCE_EN
        expect_key(4'b0001, base + SD, base + SD);
`endif
        wait_to(10);
        reset = 1'b1;
        raw_in = 4'b0000;
        @(negedge clk);
        check_reset_values("midrst");
        reset = 1'b0;
        base = cyc;
        wait_to(48);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        check("midrst_not_held", 32'(key_held), 32'd0);

        // Randomized presses through the keypad model
        raw_mode = 1'b0;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            repeat ($urandom_range(0, 15)) @(negedge clk);
            key_r = 2'($urandom_range(0, 3));
            key_c = 2'($urandom_range(0, 3));
            p = cyc;
            // Detect within 2 sync cycles plus at most one missed rotation
            hi = p + (D_EFF + 4) * SD + 2;
            expect_key({key_r, key_c}, p + (D_EFF - 1) * SD + 3, hi);
            key_down = 1'b1;
            repeat ((D_EFF + 6) * SD) @(negedge clk);
            check("rnd_accepted", 32'(exp_q.size()), 32'd0);
            check("rnd_held", 32'(key_held), 32'd1);
            check("rnd_out_row", 32'(out_w), 32'(one4 << key_r));
            key_down = 1'b0;
            repeat ((D_EFF + 2) * SD + 4) @(negedge clk);
            check("rnd_released", 32'(key_held), 32'd0);
        end

        // Randomized multi-key raw patterns
        raw_mode = 1'b1;
        for (int n = 0; n < 4; n++) begin
            pat = 4'($urandom_range(0, 15));
            while ($countones(pat) < 2) pat = 4'($urandom_range(0, 15));
            raw_in = pat;
            repeat (5 * SD) @(negedge clk);
            check("rnd_multi_not_held", 32'(key_held), 32'd0);
            raw_in = 4'b0000;
            repeat (4) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
